dac_wave_player: RTL and testbench

//  AXI4 write slave downstream of the ccu DAC master port. Stores bursts of 8-bit samples into an on-chip

---
 rtl/dac_wave_player_pkg.sv | 30 +++
 rtl/dac_wave_ram.sv | 43 ++++
 rtl/dac_wave_player.sv | 192 +++++++++++++++++++
 tb/tb_dac_wave_player.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_wave_player_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dac_wave_player_pkg
//  Description : Shared constants for the DAC waveform player: control
//                register offsets, AXI write response codes and the
//                write-channel state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_wave_player_pkg;

    // Control register offsets relative to the control base address
    localparam logic [1:0] C_REG_EN     = 2'd0;
    localparam logic [1:0] C_REG_LEN_LO = 2'd1;
    localparam logic [1:0] C_REG_LEN_HI = 2'd2;
    localparam logic [1:0] C_REG_DIV    = 2'd3;

    // AXI write response codes
    localparam logic [1:0] C_BRESP_OKAY   = 2'b00;
    localparam logic [1:0] C_BRESP_SLVERR = 2'b10;

    // Write-channel FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

endpackage : dac_wave_player_pkg
`default_nettype wire

// File: rtl/dac_wave_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dac_wave_ram
//  Description : Simple dual-port DEPTH x 8 waveform RAM. Port A writes,
//                port B reads synchronously; a same-address collision
//                returns the old contents (read-first).
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_wave_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    // Write port; contents are intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read sees the pre-write value on a same-cycle collision
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : dac_wave_ram
`default_nettype wire

// File: rtl/dac_wave_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dac_wave_player
//  Description : AXI4 write slave that loads 8-bit samples into a waveform
//                RAM plus a small control bank (EN/LEN/DIV), and replays the
//                stored waveform cyclically to the DAC pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_wave_player
    import dac_wave_player_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [15:0] CTRL_BASE = 16'hFF00
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic [15:0] dac_axi_awaddr,
    input  logic        dac_axi_awvalid,
    output logic        dac_axi_awready,
    input  logic [7:0]  dac_axi_wdata,
    input  logic        dac_axi_wvalid,
    output logic        dac_axi_wready,
    input  logic        dac_axi_wlast,
    output logic [1:0]  dac_axi_bresp,
    output logic        dac_axi_bvalid,
    input  logic        dac_axi_bready,
    output logic [7:0]  dac_data,
    output logic        dac_strobe,
    output logic        playing
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [16:0] C_DEPTH = 17'(DEPTH);

    // ---------------- write channel ----------------
    wr_state_t   r_state, w_state_nxt;
    logic        r_awready, r_wready, r_bvalid;
    logic [1:0]  r_bresp;
    logic [15:0] r_addr;
    logic        r_err;

    logic w_aw_hs, w_w_hs, w_b_hs;
    logic w_ram_hit, w_ctrl_hit, w_beat_err;

    // ---------------- register bank ----------------
    logic          r_en;
    logic [AW-1:0] r_len;
    logic [7:0]    r_div;
    logic [15:0]   w_len_ext;

    // ---------------- playback ----------------
    logic [7:0]    r_div_cnt;
    logic [AW-1:0] r_rd_ptr;
    logic          r_tick_d;
    logic [7:0]    r_dac_data;
    logic          r_strobe;
    logic          w_tick;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_ram_q;

    assign w_aw_hs    = dac_axi_awvalid & r_awready;
    assign w_w_hs     = dac_axi_wvalid & r_wready;
    assign w_b_hs     = r_bvalid & dac_axi_bready;
    assign w_ram_hit  = ({1'b0, r_addr} < C_DEPTH);
    // The control window is four bytes on a 4-byte aligned base
    assign w_ctrl_hit = (r_addr[15:2] == CTRL_BASE[15:2]);
    assign w_beat_err = ~(w_ram_hit | w_ctrl_hit);

    // Next-state selection for the write channel
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_aw_hs)                  w_state_nxt = ST_DATA;
            ST_DATA: if (w_w_hs && dac_axi_wlast)  w_state_nxt = ST_RESP;
            ST_RESP: if (w_b_hs)                   w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    // Handshake outputs are registered images of the next state
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= C_BRESP_OKAY;
        end else begin
            r_awready <= (w_state_nxt == ST_IDLE);
            r_wready  <= (w_state_nxt == ST_DATA);
            r_bvalid  <= (w_state_nxt == ST_RESP);
            if (w_w_hs && dac_axi_wlast)
                r_bresp <= (r_err | w_beat_err) ? C_BRESP_SLVERR : C_BRESP_OKAY;
            else if (w_b_hs)
                r_bresp <= C_BRESP_OKAY;
        end
    end

    // Burst address tracking and sticky error flag
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_addr <= '0;
            r_err  <= 1'b0;
        end else if (w_aw_hs) begin
            r_addr <= dac_axi_awaddr;
            r_err  <= 1'b0;
        end else if (w_w_hs) begin
            r_addr <= r_addr + 16'd1;
            if (w_beat_err) r_err <= 1'b1;
        end
    end

    assign w_len_ext = 16'(r_len);

    // Control register writes; LEN bytes are merged then truncated to AW bits
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_en  <= 1'b0;
            r_len <= AW'(DEPTH - 1);
            r_div <= '0;
        end else if (w_w_hs && w_ctrl_hit) begin
            case (r_addr[1:0])
                C_REG_EN:     r_en  <= dac_axi_wdata[0];
                C_REG_LEN_LO: r_len <= AW'({w_len_ext[15:8], dac_axi_wdata});
                C_REG_LEN_HI: r_len <= AW'({dac_axi_wdata, w_len_ext[7:0]});
                C_REG_DIV:    r_div <= dac_axi_wdata;
                default:      r_en  <= r_en;
            endcase
        end
    end

    // A pointer left beyond a freshly shortened LEN restarts from 0
    assign w_tick    = r_en & (r_div_cnt >= r_div);
    assign w_rd_addr = (r_rd_ptr > r_len) ? '0 : r_rd_ptr;

    // Sample-rate divider and read pointer
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_div_cnt <= '0;
            r_rd_ptr  <= '0;
        end else if (!r_en) begin
            r_div_cnt <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_div_cnt <= w_tick ? 8'd0 : r_div_cnt + 8'd1;
            if (w_tick)
                r_rd_ptr <= (w_rd_addr == r_len) ? '0 : w_rd_addr + AW'(1);
        end
    end

    // DAC output stage: present the sample the cycle after its RAM read
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_tick_d   <= 1'b0;
            r_strobe   <= 1'b0;
            r_dac_data <= '0;
        end else begin
            r_tick_d <= w_tick;
            r_strobe <= r_tick_d & r_en;
            if (r_tick_d && r_en) r_dac_data <= w_ram_q;
        end
    end

    dac_wave_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (axi_aclk),
        .i_wr_en   (w_w_hs & w_ram_hit),
        .i_wr_addr (r_addr[AW-1:0]),
        .i_wr_data (dac_axi_wdata),
        .i_rd_en   (w_tick),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    assign dac_axi_awready = r_awready;
    assign dac_axi_wready  = r_wready;
    assign dac_axi_bvalid  = r_bvalid;
    assign dac_axi_bresp   = r_bresp;
    assign dac_data        = r_dac_data;
    assign dac_strobe      = r_strobe;
    assign playing         = r_en;

endmodule : dac_wave_player
`default_nettype wire

// File: tb/tb_dac_wave_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dac_wave_player
//  Description : Self-checking bench for dac_wave_player with a behavioural
//                model of the memory map and the expected playback stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_wave_player;

    localparam int          DEPTH     = 1024;
    localparam logic [15:0] CTRL_BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [7:0]  wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        wlast = 1'b0;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  dac_data;
    logic        dac_strobe;
    logic        playing;

    always #5 clk = ~clk;

    dac_wave_player #(.DEPTH(DEPTH), .CTRL_BASE(CTRL_BASE)) dut (
        .axi_aclk        (clk),
        .axi_aresetn     (rst_n),
        .dac_axi_awaddr  (awaddr),
        .dac_axi_awvalid (awvalid),
        .dac_axi_awready (awready),
        .dac_axi_wdata   (wdata),
        .dac_axi_wvalid  (wvalid),
        .dac_axi_wready  (wready),
        .dac_axi_wlast   (wlast),
        .dac_axi_bresp   (bresp),
        .dac_axi_bvalid  (bvalid),
        .dac_axi_bready  (bready),
        .dac_data        (dac_data),
        .dac_strobe      (dac_strobe),
        .playing         (playing)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log: cycle stamp and data for every observed DAC update
    int         s_cyc[$];
    logic [7:0] s_dat[$];
    always @(negedge clk) begin
        if (rst_n && dac_strobe) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(dac_data);
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] m_ram [DEPTH];
    logic       m_en;
    int         m_len;
    int         m_div;
    logic       m_err;
    logic [7:0] bdata [16];

    function automatic void model_reset();
        m_en  = 1'b0;
        m_len = DEPTH - 1;
        m_div = 0;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
        if (int'(a) < DEPTH)           m_ram[a] = d;
        else if (a == CTRL_BASE)       m_en  = d[0];
        else if (a == CTRL_BASE + 1)   m_len = ((m_len / 256) * 256 + int'(d)) % DEPTH;
        else if (a == CTRL_BASE + 2)   m_len = (int'(d) * 256 + m_len % 256) % DEPTH;
        else if (a == CTRL_BASE + 3)   m_div = int'(d);
        else                           m_err = 1'b1;
    endfunction

    // Drives one complete AXI write burst; beats come from bdata[]
    task automatic axi_burst(input logic [15:0] addr, input int n, input int bhold,
                             output logic [1:0] resp, output int aw_wait, output int b_wait,
                             output logic hold_ok, output logic aw_after, output int beat_cyc,
                             output logic tmo);
        int t;
        tmo = 1'b0; hold_ok = 1'b1; m_err = 1'b0;
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 20) begin @(negedge clk); t++; end
        if (!awready) tmo = 1'b1;
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
        aw_wait = 1; t = 0;
        while (!wready && t < 20) begin @(negedge clk); aw_wait++; t++; end
        for (int i = 0; i < n; i++) begin
            wdata = bdata[i]; wvalid = 1'b1; wlast = (i == n - 1);
            t = 0;
            while (!wready && t < 20) begin @(negedge clk); t++; end
            if (!wready) tmo = 1'b1;
            @(posedge clk); @(negedge clk);
            model_write(addr + 16'(i), bdata[i]);
        end
        beat_cyc = cyc; wvalid = 1'b0; wlast = 1'b0;
        b_wait = 1; t = 0;
        while (!bvalid && t < 20) begin @(negedge clk); b_wait++; t++; end
        if (!bvalid) tmo = 1'b1;
        resp = bresp;
        for (int h = 0; h < bhold; h++) begin
            if (!bvalid || bresp !== resp || awready) hold_ok = 1'b0;
            @(negedge clk);
        end
        if (!bvalid || bresp !== resp || awready) hold_ok = 1'b0;
        bready = 1'b1;
        @(posedge clk); @(negedge clk);
        bready = 1'b0;
        aw_after = awready;
    endtask

    task automatic wait_strobes(input int n, input int lim);
        int t = 0;
        while (s_cyc.size() < n && t < lim) begin @(negedge clk); t++; end
    endtask

    logic [1:0] r_resp;
    int         r_aw_wait, r_b_wait, r_beat;
    logic       r_hold_ok, r_aw_after, r_tmo;

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, bresp, dac_data, dac_strobe, playing} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got aw=%b w=%b bv=%b br=%b d=%h s=%b p=%b want all 0",
                     awready, wready, bvalid, bresp, dac_data, dac_strobe, playing);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin
            errors++; $display("FAIL reset_awready got %b want 1", awready);
        end
        // Stray write data while idle must not be accepted
        wvalid = 1'b1; wdata = 8'hA5;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (wready !== 1'b0) begin
                errors++; $display("FAIL idle_wready got %b want 0", wready);
            end
        end
        wvalid = 1'b0;
    endtask

    task automatic test_basic_burst();
        bdata[0] = 8'h11; bdata[1] = 8'h22; bdata[2] = 8'h33; bdata[3] = 8'h44;
        axi_burst(16'h0000, 4, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        checks++;
        if (r_tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", r_tmo); end
        checks++;
        if (r_resp !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b want 00", r_resp); end
        checks++;
        if (r_aw_wait != 1) begin errors++; $display("FAIL basic_aw_to_w got %0d want 1", r_aw_wait); end
        checks++;
        if (r_b_wait != 1) begin errors++; $display("FAIL basic_last_to_b got %0d want 1", r_b_wait); end
        checks++;
        if (r_aw_after !== 1'b1) begin errors++; $display("FAIL basic_awready_after got %b want 1", r_aw_after); end
    endtask

    task automatic test_playback();
        int e_cyc;
        int n;
        bdata[0] = 8'h03; bdata[1] = 8'h00; bdata[2] = 8'h02;
        axi_burst(CTRL_BASE + 16'd1, 3, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        checks++;
        if (r_resp !== 2'b00) begin errors++; $display("FAIL cfg_bresp got %b want 00", r_resp); end
        s_cyc.delete(); s_dat.delete();
        bdata[0] = 8'h01;
        axi_burst(CTRL_BASE, 1, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        checks++;
        if (playing !== m_en) begin errors++; $display("FAIL play_playing got %b want %b", playing, m_en); end
        wait_strobes(8, 100);
        checks++;
        if (s_cyc.size() < 8) begin errors++; $display("FAIL play_count got %0d want 8", s_cyc.size()); end
        n = (s_cyc.size() < 8) ? s_cyc.size() : 8;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (s_cyc[k] != r_beat + m_div + 2 + k * (m_div + 1)) begin
                errors++;
                $display("FAIL play_time[%0d] got %0d want %0d", k, s_cyc[k] - r_beat,
                         m_div + 2 + k * (m_div + 1));
            end
            checks++;
            if (s_dat[k] !== m_ram[k % (m_len + 1)]) begin
                errors++;
                $display("FAIL play_data[%0d] got %h want %h", k, s_dat[k], m_ram[k % (m_len + 1)]);
            end
        end
        bdata[0] = 8'h00;
        axi_burst(CTRL_BASE, 1, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        e_cyc = r_beat;
        repeat (10) @(negedge clk);
        n = 0;
        foreach (s_cyc[i]) if (s_cyc[i] > e_cyc) n++;
        checks++;
        if (n != 0) begin errors++; $display("FAIL stop_strobes got %0d want 0", n); end
        checks++;
        if (playing !== 1'b0) begin errors++; $display("FAIL stop_playing got %b want 0", playing); end
    endtask

    task automatic test_invalid_burst();
        logic [1:0] exp_resp;
        bdata[0] = 8'($urandom);
        bdata[1] = 8'($urandom) & 8'hFE;
        axi_burst(16'hFEFF, 2, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        exp_resp = m_err ? 2'b10 : 2'b00;
        checks++;
        if (r_resp !== exp_resp) begin errors++; $display("FAIL invalid_bresp got %b want %b", r_resp, exp_resp); end
        checks++;
        if (playing !== m_en) begin errors++; $display("FAIL invalid_playing got %b want %b", playing, m_en); end
        for (int i = 0; i < 4; i++) bdata[i] = 8'($urandom);
        axi_burst(16'h0004, 4, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        checks++;
        if (r_resp !== 2'b00 || r_aw_wait != 1) begin
            errors++; $display("FAIL after_invalid got bresp=%b aw_to_w=%0d want 00/1", r_resp, r_aw_wait);
        end
    endtask

    task automatic test_bready_hold();
        bdata[0] = 8'($urandom); bdata[1] = 8'($urandom);
        axi_burst(16'h0008, 2, 5, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        checks++;
        if (r_hold_ok !== 1'b1) begin errors++; $display("FAIL hold_stable got %b want 1", r_hold_ok); end
        checks++;
        if (r_resp !== 2'b00) begin errors++; $display("FAIL hold_bresp got %b want 00", r_resp); end
        checks++;
        if (r_aw_after !== 1'b1) begin errors++; $display("FAIL hold_awready_after got %b want 1", r_aw_after); end
    endtask

    task automatic test_random_playback();
        int len, div, cnt, n;
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(1, 8);
            div = $urandom_range(0, 4);
            for (int i = 0; i < len; i++) bdata[i] = 8'($urandom);
            axi_burst(16'h0000, len, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
            bdata[0] = 8'(len - 1); bdata[1] = 8'h00; bdata[2] = 8'(div);
            axi_burst(CTRL_BASE + 16'd1, 3, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
            s_cyc.delete(); s_dat.delete();
            bdata[0] = 8'h01;
            axi_burst(CTRL_BASE, 1, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
            cnt = 2 * len + 2;
            wait_strobes(cnt, cnt * (div + 1) + 20);
            checks++;
            if (s_cyc.size() < cnt) begin errors++; $display("FAIL rnd_count got %0d want %0d", s_cyc.size(), cnt); end
            n = (s_cyc.size() < cnt) ? s_cyc.size() : cnt;
            for (int k = 0; k < n; k++) begin
                checks++;
                if (s_cyc[k] != r_beat + m_div + 2 + k * (m_div + 1) ||
                    s_dat[k] !== m_ram[k % (m_len + 1)]) begin
                    errors++;
                    $display("FAIL rnd_sample[%0d] got t=%0d d=%h want t=%0d d=%h", k, s_cyc[k] - r_beat,
                             s_dat[k], m_div + 2 + k * (m_div + 1), m_ram[k % (m_len + 1)]);
                end
            end
            bdata[0] = 8'h00;
            axi_burst(CTRL_BASE, 1, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_len_shrink();
        int exp_idx[4];
        exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 0; exp_idx[3] = 1;
        for (int i = 0; i < 4; i++) bdata[i] = 8'($urandom);
        axi_burst(16'h0000, 4, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        bdata[0] = 8'h03; bdata[1] = 8'h00; bdata[2] = 8'd9;
        axi_burst(CTRL_BASE + 16'd1, 3, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        s_cyc.delete(); s_dat.delete();
        bdata[0] = 8'h01;
        axi_burst(CTRL_BASE, 1, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        wait_strobes(3, 100);
        checks++;
        if (s_dat.size() < 3 || s_dat[2] !== m_ram[2]) begin
            errors++; $display("FAIL shrink_pre got n=%0d want RAM[2]=%h", s_dat.size(), m_ram[2]);
        end
        bdata[0] = 8'h01; bdata[1] = 8'h00;
        axi_burst(CTRL_BASE + 16'd1, 2, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        wait_strobes(7, 150);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (s_dat.size() < 4 + k) begin
                errors++; $display("FAIL shrink_data[%0d] got missing want %h", k, m_ram[exp_idx[k]]);
            end else if (s_dat[3 + k] !== m_ram[exp_idx[k]]) begin
                errors++; $display("FAIL shrink_data[%0d] got %h want %h", k, s_dat[3 + k], m_ram[exp_idx[k]]);
            end
        end
        bdata[0] = 8'h00;
        axi_burst(CTRL_BASE, 1, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int t;
        int n;
        @(negedge clk);
        awaddr = 16'h0010; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 8'($urandom); wvalid = 1'b1; wlast = 1'b0;
            t = 0;
            while (!wready && t < 20) begin @(negedge clk); t++; end
            @(posedge clk); @(negedge clk);
            model_write(16'h0010 + 16'(i), wdata);
        end
        wdata = 8'($urandom);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, bvalid, bresp, dac_data, dac_strobe, playing} !== 15'd0) begin
            errors++;
            $display("FAIL midreset_outputs got aw=%b w=%b bv=%b br=%b d=%h s=%b p=%b want all 0",
                     awready, wready, bvalid, bresp, dac_data, dac_strobe, playing);
        end
        wvalid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL midreset_awready got %b want 1", awready); end
        for (int i = 0; i < 4; i++) bdata[i] = 8'($urandom);
        axi_burst(16'h0000, 4, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        checks++;
        if (r_resp !== 2'b00 || r_tmo !== 1'b0) begin
            errors++; $display("FAIL midreset_burst got bresp=%b tmo=%b want 00/0", r_resp, r_tmo);
        end
        bdata[0] = 8'h03; bdata[1] = 8'h00;
        axi_burst(CTRL_BASE + 16'd1, 2, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        s_cyc.delete(); s_dat.delete();
        bdata[0] = 8'h01;
        axi_burst(CTRL_BASE, 1, 0, r_resp, r_aw_wait, r_b_wait, r_hold_ok, r_aw_after, r_beat, r_tmo);
        wait_strobes(6, 40);
        checks++;
        if (s_cyc.size() < 6) begin errors++; $display("FAIL div0_count got %0d want 6", s_cyc.size()); end
        n = (s_cyc.size() < 6) ? s_cyc.size() : 6;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (s_cyc[k] != r_beat + m_div + 2 + k * (m_div + 1) ||
                s_dat[k] !== m_ram[k % (m_len + 1)]) begin
                errors++;
                $display("FAIL div0_sample[%0d] got t=%0d d=%h want t=%0d d=%h", k, s_cyc[k] - r_beat,
                         s_dat[k], m_div + 2 + k * (m_div + 1), m_ram[k % (m_len + 1)]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_burst();
        test_playback();
        test_invalid_burst();
        test_bready_hold();
        test_random_playback();
        test_len_shrink();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule : tb_dac_wave_player
`default_nettype wire
